// File: rtl/lnvd_pkg.sv
// Shared constants and sample/frame types for the per-channel process delay line.
package lnvd_pkg;

  localparam int LNVD_DATA_W    = 12;
  localparam int LNVD_NUM_CH    = 4;
  localparam int LNVD_DLY_DEPTH = 256;

  typedef logic [LNVD_DATA_W-1:0] lnvd_sample_t;
  typedef lnvd_sample_t [LNVD_NUM_CH-1:0] lnvd_frame_t;

endpackage

// File: rtl/lnvd_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module lnvd_sdp_ram #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lnvd_process_delay_buffer.sv
// Per-channel sample delay line: each strobed frame is returned 'delay' strobes later,
// zero-masked until enough samples have been written under the current delay.
module lnvd_process_delay_buffer
  import lnvd_pkg::*;
#(
  parameter int DATA_W = LNVD_DATA_W,
  parameter int NUM_CH = LNVD_NUM_CH,
  parameter int DEPTH  = LNVD_DLY_DEPTH,
  parameter int DLY_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic [DLY_W-1:0]  delay,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out_buffer1,
  output logic [DATA_W-1:0] data_out_buffer2,
  output logic [DATA_W-1:0] data_out_buffer3,
  output logic [DATA_W-1:0] data_out_buffer4,
  output logic              out_valid,
  output logic              primed
);

  localparam logic [DLY_W-1:0] FILL_MAX = DLY_W'(DEPTH - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  logic [DLY_W-1:0] wr_ptr_reg;
  logic [DLY_W-1:0] fill_reg;
  logic [DLY_W-1:0] dly_reg;
  logic [DLY_W-1:0] dly_next;
  logic [DLY_W-1:0] fill_next;
  logic [DLY_W-1:0] rd_addr;
  logic             strobe;
  logic             dly_changed;
  logic             read_primed;

  logic             rd_valid_reg;
  logic             rd_primed_reg;
  logic             keep_data;

  logic [NUM_CH-1:0][DATA_W-1:0] wr_frame;
  logic [NUM_CH-1:0][DATA_W-1:0] rd_frame;
  logic [NUM_CH-1:0][DATA_W-1:0] masked_frame;
  logic [NUM_CH-1:0][DATA_W-1:0] out_frame_reg;

  assign strobe      = sample_en & ~flush;
  assign dly_next    = (delay == '0) ? DLY_ONE : delay;
  assign dly_changed = (dly_next != dly_reg);
  // A delay change invalidates everything already in the line for this read.
  assign read_primed = ~dly_changed && (fill_reg >= dly_next);
  // dly_next >= 1, so this never aliases the slot being written.
  assign rd_addr     = wr_ptr_reg - dly_next;
  assign wr_frame    = {data_in4, data_in3, data_in2, data_in1};

  always_comb begin
    fill_next = fill_reg;
    if (dly_changed) begin
      fill_next = DLY_ONE;
    end else if (fill_reg != FILL_MAX) begin
      fill_next = fill_reg + DLY_ONE;
    end
  end

  lnvd_sdp_ram #(
    .WIDTH (NUM_CH * DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(DLY_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (strobe),
    .wr_addr(wr_ptr_reg),
    .wr_data(wr_frame),
    .rd_en  (strobe),
    .rd_addr(rd_addr),
    .rd_data(rd_frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      dly_reg    <= DLY_ONE;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
    end else if (sample_en) begin
      wr_ptr_reg <= wr_ptr_reg + DLY_ONE;
      fill_reg   <= fill_next;
      dly_reg    <= dly_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg  <= 1'b0;
      rd_primed_reg <= 1'b0;
    end else begin
      rd_valid_reg  <= strobe;
      rd_primed_reg <= strobe & read_primed;
    end
  end

  // A flush landing while a read is in flight still lets it fire, but as zero.
  assign keep_data = rd_primed_reg & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
      assign masked_frame[gi] = keep_data ? rd_frame[gi] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_frame_reg <= '0;
      out_valid     <= 1'b0;
      primed        <= 1'b0;
    end else begin
      out_valid <= rd_valid_reg;
      if (rd_valid_reg) begin
        out_frame_reg <= masked_frame;
      end
      if (flush) begin
        primed <= 1'b0;
      end else if (rd_valid_reg) begin
        primed <= rd_primed_reg;
      end
    end
  end

  assign data_out_buffer1 = out_frame_reg[0];
  assign data_out_buffer2 = out_frame_reg[1];
  assign data_out_buffer3 = out_frame_reg[2];
  assign data_out_buffer4 = out_frame_reg[3];

endmodule
